// File: rtl/bias_pred_pkg.sv
// Shared types, widths and the saturating weight update for the bias-weight table.
package bias_pred_pkg;

    localparam int IDX_W = 10;
    localparam int W_W   = 2;
    localparam logic [W_W-1:0] W_MAX = {W_W{1'b1}};

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             taken;
    } upd_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    // One extra bit catches both overflow past W_MAX and underflow below zero.
    function automatic logic [W_W-1:0] sat_update(input logic [W_W-1:0] w, input logic taken);
        logic [W_W:0] one;
        logic [W_W:0] ext;
        logic [W_W-1:0] res;
        one = {{W_W{1'b0}}, 1'b1};
        ext = taken ? ({1'b0, w} + one) : ({1'b0, w} - one);
        if (taken) begin
            res = (ext > {1'b0, W_MAX}) ? W_MAX : ext[W_W-1:0];
        end else begin
            res = ext[W_W] ? '0 : ext[W_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bias_update_ctrl_if.sv
// Prediction read-port, training-request and table-port signals of bias_update_ctrl.
interface bias_update_ctrl_if;
    import bias_pred_pkg::*;

    logic             pred_valid;
    logic [IDX_W-1:0] pred_index;
    logic             pred_stall;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic [IDX_W-1:0] tbl_index;
    logic [W_W-1:0]   tbl_weight;
    logic [IDX_W-1:0] tbl_index_update;
    logic [W_W-1:0]   tbl_weight_update;
    logic             tbl_en;
    logic             busy;

    modport slave (
        input  pred_valid, pred_index, upd_valid, upd_index, upd_taken, tbl_weight,
        output pred_stall, upd_ready, tbl_index, tbl_index_update, tbl_weight_update,
               tbl_en, busy
    );

    modport master (
        output pred_valid, pred_index, upd_valid, upd_index, upd_taken, tbl_weight,
        input  pred_stall, upd_ready, tbl_index, tbl_index_update, tbl_weight_update,
               tbl_en, busy
    );

endinterface

// File: rtl/bias_upd_fifo.sv
// Synchronous training-request FIFO with full/empty/count flags.
// Latency: pushed entry visible at pop_dat one cycle after the push edge.
// Backpressure: push ignored while full (even with a simultaneous pop); pop ignored while empty.
module bias_upd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/bias_update_ctrl.sv
// Bias-weight training sequencer: buffers requests and read-modify-writes 2-bit weights.
// Latency: push to table write in 2 cycles when the read port is free; one update per 2 cycles.
// Backpressure: upd_ready drops when the FIFO is full; prediction stalls only on a starvation grant.
module bias_update_ctrl
    import bias_pred_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    bias_update_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [STV_W-1:0] starve_cnt;
    upd_entry_t       push_dat;
    upd_entry_t       head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             grant;
    logic             tbl_en;
    logic [IDX_W-1:0] tbl_index;
    logic [W_W-1:0]   tbl_weight_update;

    assign push_dat  = '{index: bus.upd_index, taken: bus.upd_taken};
    assign fifo_push = bus.upd_valid && !fifo_full;

    bias_upd_fifo #(
        .W     ($bits(upd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write enable is masked by rst so an RMW caught by reset never reaches the table.
    always_comb begin
        state_nxt         = state;
        grant             = 1'b0;
        fifo_pop          = 1'b0;
        tbl_en            = 1'b0;
        tbl_index         = bus.pred_index;
        tbl_weight_update = sat_update(bus.tbl_weight, head.taken);
        case (state)
            ST_IDLE: begin
                grant = !rst && !fifo_empty && (!bus.pred_valid || (starve_cnt == STV_MAX));
                if (grant) begin
                    tbl_index = head.index;
                    state_nxt = ST_RMW;
                end
            end
            ST_RMW: begin
                tbl_en    = !rst;
                fifo_pop  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (fifo_empty || grant) begin
                starve_cnt <= '0;
            end else if (bus.pred_valid && (starve_cnt != STV_MAX)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    assign bus.pred_stall        = bus.pred_valid && grant;
    assign bus.upd_ready         = !fifo_full;
    assign bus.busy              = (fifo_count != '0) || (state == ST_RMW);
    assign bus.tbl_index         = tbl_index;
    assign bus.tbl_en            = tbl_en;
    assign bus.tbl_index_update  = head.index;
    assign bus.tbl_weight_update = tbl_weight_update;

endmodule

// File: doc/bias_update_ctrl.md
# bias_update_ctrl

Sequencer for the bias-weight table of the bias-free neural predictor. Accepts branch-resolution training requests, buffers them in a small FIFO and performs read-modify-write of 2-bit saturating bias weights. The table's single read port is shared with the fetch-stage prediction lookup, and this block arbitrates it. Sits between the branch-resolution stage and the bias-weight table, driving both the table's read index and its write port.

## Interface
- IDX_W, 10, table index width (1024 entries)
- W_W, 2, weight width
- FIFO_DEPTH, 4, training-request FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive blocked cycles before update forces the read port
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pred_valid  in  1  prediction lookup requests the read port this cycle
- pred_index  in  IDX_W  prediction lookup index
- pred_stall  out  1  read port taken by update this cycle; fetch must replay lookup
- upd_valid  in  1  training request valid
- upd_ready  out  1  FIFO can accept (= !full)
- upd_index  in  IDX_W  entry to train
- upd_taken  in  1  resolved direction
- tbl_index  out  IDX_W  table read index (registered read, data next cycle)
- tbl_weight  in  W_W  table read data
- tbl_index_update  out  IDX_W  table write index
- tbl_weight_update  out  W_W  table write data
- tbl_en  out  1  table write enable
- busy  out  1  FIFO non-empty or RMW in flight

## Operation
- Weight: unsigned saturating counter, 0..3; taken → min(w+1,3), not-taken → max(w-1,0). Arithmetic done in W_W+1 bits, then clamped.
- FIFO: push when upd_valid && upd_ready; entry = {upd_index, upd_taken}. No push-through when full.
- FSM states IDLE, RMW.
  - IDLE: grant = FIFO non-empty && (!pred_valid || starve_cnt == STARVE_LIMIT). On grant: tbl_index = head index, → RMW. Else tbl_index = pred_index.
  - RMW: tbl_weight holds head entry's weight; drive tbl_en=1, tbl_index_update=head index, tbl_weight_update=saturated result; pop FIFO; tbl_index = pred_index; → IDLE.
- pred_stall = pred_valid && grant (forced grant only).
- starve_cnt: increments in IDLE when FIFO non-empty && pred_valid && no grant; clears on grant or when FIFO empty; saturates at STARVE_LIMIT.
- Hazards: consecutive requests to the same index are safe because the write (end of RMW) precedes the next update read (earliest next IDLE cycle). A prediction read of the index being written in the same RMW cycle returns the old weight; this is accepted.
- Reset: FIFO emptied, state IDLE, starve_cnt 0; in-flight RMW discarded with no write.

## Timing
- Reset values: tbl_en 0, pred_stall 0, busy 0, upd_ready 1 (first cycle after rst deasserts), tbl_index = pred_index.
- Minimum latency push → tbl_en: 2 cycles (push at T, grant at T+1, write at T+2).
- Throughput: one update per 2 cycles when the read port is free.
- Forced grant at most once per STARVE_LIMIT+1 blocked cycles.
- upd_ready combinational from registered FIFO count. tbl_en, tbl_index_update, tbl_weight_update combinational from state, head and tbl_weight.
- Push and pop in the same cycle: count unchanged.

## Structure
- Package bias_pred_pkg: IDX_W, W_W, W_MAX constant, FIFO entry struct {index, taken}, state enum, function sat_update(w, taken).
- Sub-module bias_upd_fifo: synchronous FIFO with full/empty/count. The FSM, arbitration and starvation counter stay in the top module.

## Test plan
- Single update: reset, push {idx 5, taken}, table w[5]=1, pred_valid=0 → tbl_en in cycle T+2, index 5, data 2; busy falls after.
- Saturation: push taken ×3 to idx 9 with w=3, then not-taken ×4 with w=0 → every write data 3, then 0.
- Back-to-back same index: push idx 7 taken ×3 with start w=0 → writes 1, 2, 3 on alternate cycles.
- Full FIFO: push 5 entries without draining (pred_valid held) → upd_ready=0 after 4, fifth not accepted, count stays 4.
- Starvation: FIFO non-empty, pred_valid held high → after 8 blocked cycles pred_stall=1 for one cycle, tbl_index = head, write follows next cycle.
- Reset mid-RMW: assert rst in RMW cycle → tbl_en 0, FIFO empty, busy 0, upd_ready 1 next cycle.
